// File: rtl/garp_row_sequencer.sv
// garp_row_sequencer: command-driven row WRITE/READ sequencer for the GarpAccel memory bus.
// Ports: clk/reset; cmd_* command stream in; wr_* write words in; rd_* captured words out;
//   accel_* drive/observe the GarpAccel bus; busy/done/err status.
module garp_row_sequencer #(
    parameter int LANES    = 24,
    parameter int LANE_W   = 2,
    parameter int ADDR_W   = 5,
    parameter int NUM_ROWS = 32,
    parameter int RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic [ADDR_W-1:0]         cmd_base,
    input  logic [ADDR_W:0]           cmd_count,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [LANES*LANE_W-1:0]   wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [LANES*LANE_W-1:0]   rd_data,
    output logic [ADDR_W-1:0]         accel_addr,
    output logic [LANES*LANE_W-1:0]   accel_bus_in,
    output logic                      accel_wr_en,
    input  logic [LANES*LANE_W-1:0]   accel_bus_out,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int SUM_W = ADDR_W + 2;
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] row;
    logic [ADDR_W:0]   remaining;
    logic [CNT_W-1:0]  lat_cnt;

    logic             cmd_fire;
    logic             wr_fire;
    logic             rd_fire;
    logic [SUM_W-1:0] span;
    logic             cmd_bad;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    // Widened sum so base+count cannot overflow before the range test.
    assign span    = SUM_W'(cmd_base) + SUM_W'(cmd_count);
    assign cmd_bad = (cmd_count == '0) || (span > SUM_W'(NUM_ROWS));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_fire && !cmd_bad)
                    state_nxt = cmd_op ? S_RD_ADDR : S_WRITE;
            end
            // The last beat's strobe lands while remaining is already 0;
            // leaving one cycle later puts done after that strobe.
            S_WRITE: begin
                if (remaining == '0) state_nxt = S_DONE;
            end
            S_RD_ADDR: state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (lat_cnt == CNT_W'(1)) state_nxt = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (rd_fire)
                    state_nxt = (remaining == 1) ? S_DONE : S_RD_ADDR;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = (state == S_IDLE);
        wr_ready  = (state == S_WRITE) && (remaining != '0);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // Datapath: row walk, bus drive and read capture
    always_ff @(posedge clk) begin
        if (reset) begin
            row          <= '0;
            remaining    <= '0;
            lat_cnt      <= '0;
            accel_addr   <= '0;
            accel_bus_in <= '0;
            accel_wr_en  <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            err          <= 1'b0;
        end else begin
            err         <= cmd_fire && cmd_bad;
            accel_wr_en <= wr_fire;
            unique case (state)
                S_IDLE: begin
                    if (cmd_fire && !cmd_bad) begin
                        row       <= cmd_base;
                        remaining <= cmd_count;
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        accel_addr   <= row;
                        accel_bus_in <= wr_data;
                        row          <= row + 1'b1;
                        remaining    <= remaining - 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    accel_addr <= row;
                    lat_cnt    <= CNT_W'(RD_LAT);
                end
                S_RD_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == CNT_W'(1)) begin
                        rd_data  <= accel_bus_out;
                        rd_valid <= 1'b1;
                    end
                end
                S_RD_HOLD: begin
                    if (rd_fire) begin
                        rd_valid  <= 1'b0;
                        row       <= row + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_garp_row_sequencer.sv
// tb_garp_row_sequencer: directed bench for garp_row_sequencer with a behavioural
// GarpAccel row memory (rows reset to row*0x111) attached to the accel bus.
module tb_garp_row_sequencer;

    localparam int LANES    = 24;
    localparam int LANE_W   = 2;
    localparam int W        = LANES * LANE_W;
    localparam int ADDR_W   = 5;
    localparam int NUM_ROWS = 32;
    localparam int RD_LAT   = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_count;
    logic              wr_valid;
    logic              wr_ready;
    logic [W-1:0]      wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [W-1:0]      rd_data;
    logic [ADDR_W-1:0] accel_addr;
    logic [W-1:0]      accel_bus_in;
    logic              accel_wr_en;
    logic [W-1:0]      accel_bus_out;
    logic              busy;
    logic              done;
    logic              err;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] mem     [NUM_ROWS];
    logic [W-1:0] exp_mem [NUM_ROWS];

    garp_row_sequencer #(
        .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W),
        .NUM_ROWS(NUM_ROWS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .accel_addr(accel_addr), .accel_bus_in(accel_bus_in),
        .accel_wr_en(accel_wr_en), .accel_bus_out(accel_bus_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Accelerator row memory: row strobe writes, combinational readout.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROWS; i++) mem[i] <= W'(i) * W'(48'h111);
        end else if (accel_wr_en) begin
            mem[accel_addr] <= accel_bus_in;
        end
    end
    assign accel_bus_out = mem[accel_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic op;
        int   base;
        int   count;
        int   stall_at;
        int   stall_len;
        int   hold_len;
        logic exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [W-1:0] wdata(input int r);
        return 48'hA5A5_0000_0000 ^ (W'(r) * 48'h0001_0203_0405);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_exp();
        for (int i = 0; i < NUM_ROWS; i++) exp_mem[i] = W'(i) * W'(48'h111);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_addr"},  64'(accel_addr),   64'(0));
        check({tag, "_busin"}, 64'(accel_bus_in), 64'(0));
        check({tag, "_wren"},  64'(accel_wr_en),  64'(0));
        check({tag, "_rdv"},   64'(rd_valid),     64'(0));
        check({tag, "_rdd"},   64'(rd_data),      64'(0));
        check({tag, "_busy"},  64'(busy),         64'(0));
        check({tag, "_done"},  64'(done),         64'(0));
        check({tag, "_err"},   64'(err),          64'(0));
        check({tag, "_cmdrdy"}, 64'(cmd_ready),   64'(1));
    endtask

    task automatic issue(input logic op, input int base, input int count,
                         output bit ok);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = ADDR_W'(base);
        cmd_count = (ADDR_W+1)'(count);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) check("cmd_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_write(input int base, input int nbeats, input int stall_at,
                            input int stall_len, input bit finish);
        bit got;
        for (int k = 0; k < nbeats; k++) begin
            if (k == stall_at) begin
                wr_valid = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check("wr_stall_no_strobe", 64'(accel_wr_en), 64'(0));
                end
            end
            wr_valid = 1'b1;
            wr_data  = wdata(base + k);
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (wr_ready) begin
                    tick();
                    got = 1'b1;
                    break;
                end
                tick();
            end
            wr_valid = 1'b0;
            if (!got) check("wr_ready_timeout", 64'(0), 64'(1));
            check("wr_strobe", 64'(accel_wr_en),  64'(1));
            check("wr_addr",   64'(accel_addr),   64'(base + k));
            check("wr_bus",    64'(accel_bus_in), 64'(wdata(base + k)));
            exp_mem[base + k] = wdata(base + k);
        end
        if (finish) begin
            check("wr_done_not_with_strobe", 64'(done), 64'(0));
            tick();
            check("wr_done_pulse",  64'(done),        64'(1));
            check("wr_done_nostrb", 64'(accel_wr_en), 64'(0));
            check("wr_ready_off",   64'(wr_ready),    64'(0));
            check("wr_bus_holds",   64'(accel_bus_in), 64'(wdata(base + nbeats - 1)));
            tick();
            check("wr_done_end", 64'(done), 64'(0));
            check("wr_idle",     64'(busy), 64'(0));
        end
    endtask

    task automatic do_read(input int base, input int count, input int hold_len,
                           input bit probe_cmd);
        int n;
        for (int k = 0; k < count; k++) begin
            n = 0;
            while (!rd_valid && n < 20) begin
                tick();
                n++;
            end
            check("rd_latency", 64'(n), 64'(RD_LAT + 1));
            check("rd_data",    64'(rd_data),    64'(exp_mem[base + k]));
            check("rd_addr",    64'(accel_addr), 64'(base + k));
            if (k == 0) begin
                for (int h = 0; h < hold_len; h++) begin
                    tick();
                    check("rd_hold_valid", 64'(rd_valid),   64'(1));
                    check("rd_hold_data",  64'(rd_data),    64'(exp_mem[base]));
                    check("rd_hold_addr",  64'(accel_addr), 64'(base));
                    if (probe_cmd) check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
                end
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            check("rd_valid_clear", 64'(rd_valid), 64'(0));
        end
        check("rd_done_pulse", 64'(done),      64'(1));
        check("rd_done_nocmd", 64'(cmd_ready), 64'(0));
        tick();
        check("rd_done_end", 64'(done), 64'(0));
        check("rd_idle",     64'(busy), 64'(0));
    endtask

    initial begin
        bit ok;

        vecs[0] = '{1'b0,  4,  3,  1, 2, 0, 1'b0};
        vecs[1] = '{1'b1,  0,  2, -1, 0, 0, 1'b0};
        vecs[2] = '{1'b1,  4,  3, -1, 0, 0, 1'b0};
        vecs[3] = '{1'b1, 10,  2, -1, 0, 5, 1'b0};
        vecs[4] = '{1'b0, 30,  3, -1, 0, 0, 1'b1};
        vecs[5] = '{1'b1,  0,  0, -1, 0, 0, 1'b1};
        vecs[6] = '{1'b0,  0, 33, -1, 0, 0, 1'b1};
        vecs[7] = '{1'b0, 31,  1, -1, 0, 0, 1'b0};
        vecs[8] = '{1'b1, 31,  1, -1, 0, 0, 1'b0};
        vecs[9] = '{1'b1, 28,  4, -1, 0, 0, 1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_base  = '0;
        cmd_count = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        reset_exp();
        tick();
        tick();
        check_idle_zero("reset");
        reset = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            issue(vecs[v].op, vecs[v].base, vecs[v].count, ok);
            if (!ok) continue;
            check("accept_err",  64'(err),  64'(vecs[v].exp_err));
            check("accept_busy", 64'(busy), 64'(!vecs[v].exp_err));
            if (vecs[v].exp_err) begin
                tick();
                check("err_one_cycle", 64'(err),  64'(0));
                check("err_not_busy",  64'(busy), 64'(0));
            end else if (vecs[v].op == 1'b0) begin
                do_write(vecs[v].base, vecs[v].count, vecs[v].stall_at,
                         vecs[v].stall_len, 1'b1);
            end else begin
                do_read(vecs[v].base, vecs[v].count, vecs[v].hold_len, 1'b0);
            end
        end

        // New command offered while busy is held off until the cycle after done.
        issue(1'b1, 5, 1, ok);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_base  = ADDR_W'(6);
        cmd_count = (ADDR_W+1)'(1);
        do_read(5, 1, 3, 1'b1);
        check("busy_cmd_ready_after_done", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
        check("busy_cmd_taken", 64'(busy), 64'(1));
        do_read(6, 1, 0, 1'b0);

        // Reset in the middle of an 8-row write.
        issue(1'b0, 8, 8, ok);
        do_write(8, 3, -1, 0, 1'b0);
        reset = 1'b1;
        tick();
        check_idle_zero("midrst");
        reset = 1'b0;
        reset_exp();
        tick();
        check("midrst_no_done", 64'(done), 64'(0));
        issue(1'b1, 8, 1, ok);
        check("midrst_new_cmd", 64'(busy), 64'(1));
        do_read(8, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
